sobel_frame_ctrl: RTL
=====================

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64, meaning image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 64, meaning image height in pixels (>=3).
REQ-003 SHALL have parameter ADDR_W, default 12, meaning pixel memory address width (2**ADDR_W >= IMG_W*IMG_H).
REQ-004 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  one-cycle frame start request.
REQ-007 SHALL have port hold_i  input  1  downstream stall; freezes column issue.
REQ-008 SHALL have port mem_rd_o  output  1  pixel memory read strobe.
REQ-009 SHALL have port mem_addr_o  output  ADDR_W  pixel address, row-major (y*IMG_W+x).
REQ-010 SHALL have port mem_data_i  input  8  read data, valid exactly 1 cycle after mem_rd_o.
REQ-011 SHALL have ports d0_i/d1_i/d2_i-feeding outputs col_d0_o, col_d1_o, col_d2_o  output  8 each  pixels of rows r, r+1, r+2 at column c.
REQ-012 SHALL have port col_valid_o  output  1  column strobe, drives done_i of sobel_data_modulate.
REQ-013 SHALL have port win_valid_o  output  1  asserted with col_valid_o when c>=2 (full 3x3 window in modulator).
REQ-014 SHALL have ports win_x_o (16), win_y_o (16)  output  centre coordinates (c-1, r+1) of the current window.
REQ-015 SHALL have ports busy_o  output  1  and frame_done_o  output  1  (one-cycle end-of-frame pulse).

Function
REQ-016 SHALL implement FSM states IDLE, FETCH0, FETCH1, FETCH2, ISSUE, DONE.
REQ-017 SHALL move IDLE->FETCH0 on start_i=1 with r=0, c=0; start_i SHALL be ignored in all other states.
REQ-018 SHALL in FETCHk (k=0..2) assert mem_rd_o with mem_addr_o=(r+k)*IMG_W+c; mem_rd_o SHALL be 0 in every other state.
REQ-019 SHALL capture mem_data_i into col_d0_o in FETCH1, col_d1_o in FETCH2, col_d2_o in ISSUE entry cycle+0 (data of the read issued one cycle earlier).
REQ-020 SHALL assert col_valid_o = (state==ISSUE && !hold_i); col_d*_o SHALL stay stable throughout ISSUE.
REQ-021 SHALL remain in ISSUE while hold_i=1; on hold_i=0 it SHALL advance: c<IMG_W-1 -> c+1, FETCH0; else c=0, r+1, FETCH0 if r<IMG_H-3, else DONE.
REQ-022 SHALL give an unstalled throughput of one column per 4 cycles; first col_valid_o 4 cycles after the start_i cycle.
REQ-023 SHALL issue exactly (IMG_H-2)*IMG_W columns per frame, no skips or repeats.
REQ-024 SHALL assert frame_done_o for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL hold busy_o=1 in every state except IDLE.
REQ-026 SHALL compute addresses with ADDR_W-bit unsigned arithmetic, no wrap for legal parameters.
REQ-027 SHALL deassert win_valid_o at c=0 and c=1 of every row band (row-change flush).

Reset
REQ-028 SHALL on rst=1 (any state, including mid-frame) enter IDLE next edge with r=0, c=0.
REQ-029 SHALL reset col_d*_o=0, col_valid_o=0, win_valid_o=0, win_x_o=0, win_y_o=0, mem_rd_o=0, mem_addr_o=0, busy_o=0, frame_done_o=0.
REQ-030 SHALL give rst priority over start_i and hold_i in the same cycle.

Structure
REQ-031 SHALL take FSM state encoding and default IMG_W/IMG_H/ADDR_W from shared package sobel_pkg.
REQ-032 SHALL place r/c counters and address computation in one sub-module sobel_scan_cnt.

Verification
REQ-033 IMG_W=4, IMG_H=4, memory[i]=i, start_i pulse -> 8 col_valid_o pulses, first columns (0,4,8),(1,5,9); last (7,11,15); frame_done_o once.
REQ-034 Same setup -> win_valid_o on columns c=2,3 per band only, win_x/win_y=(1,1),(2,1),(1,2),(2,2).
REQ-035 hold_i=1 for 5 cycles during second ISSUE -> col_valid_o low for those cycles, col_d*_o stable (1,5,9), no memory reads, resumes unchanged.
REQ-036 rst=1 during third FETCH1 -> IDLE next cycle, all outputs zero; new start_i restarts at address 0.
REQ-037 start_i pulsed while busy_o=1 -> ignored; column count still 8, one frame_done_o.
REQ-038 IMG_W=3, IMG_H=3 -> exactly 3 columns, one win_valid_o with (1,1), frame_done_o 13 cycles after start.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel frame controller.
// Holds the FSM encoding and the coordinate width used by the scan counters.
package sobel_pkg;

    localparam int IMG_W_DEF  = 64;
    localparam int IMG_H_DEF  = 64;
    localparam int ADDR_W_DEF = 12;
    localparam int CRD_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        FETCH1,
        FETCH2,
        ISSUE,
        DONE
    } state_t;

endpackage

// File: rtl/sobel_scan_cnt.sv
// Row/column scan counters and row-major pixel address for one 3-row band.
// The address is for row r+row_ofs_i at column c and is combinational from the counters.
module sobel_scan_cnt
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [1:0]        row_ofs_i,
    output logic [CRD_W-1:0]  r_o,
    output logic [CRD_W-1:0]  c_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_col_o,
    output logic              last_row_o
);

    logic [CRD_W-1:0]  r_q, r_d;
    logic [CRD_W-1:0]  c_q, c_d;
    logic [ADDR_W-1:0] row_a;

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clr_i) begin
            r_d = '0;
            c_d = '0;
        end else if (adv_i) begin
            if (last_col_o) begin
                c_d = '0;
                r_d = r_q + CRD_W'(1);
            end else begin
                c_d = c_q + CRD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    always_comb begin
        last_col_o = (c_q == CRD_W'(IMG_W - 1));
        last_row_o = (r_q == CRD_W'(IMG_H - 3));
        row_a      = ADDR_W'(r_q) + ADDR_W'(row_ofs_i);
        addr_o     = row_a * ADDR_W'(IMG_W) + ADDR_W'(c_q);
        r_o        = r_q;
        c_o        = c_q;
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Walks a frame in 3-row bands, reading three vertically adjacent pixels per column
// and presenting them as one column strobe every 4 cycles; hold_i stalls in ISSUE.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              hold_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        col_d0_o,
    output logic [7:0]        col_d1_o,
    output logic [7:0]        col_d2_o,
    output logic              col_valid_o,
    output logic              win_valid_o,
    output logic [15:0]       win_x_o,
    output logic [15:0]       win_y_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    state_t            state_q, state_d;
    logic [7:0]        d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic              first_q, first_d;
    logic              cnt_clr, cnt_adv, in_win;
    logic [1:0]        row_ofs;
    logic [CRD_W-1:0]  r_cnt, c_cnt;
    logic [ADDR_W-1:0] addr;
    logic              last_col, last_row;

    sobel_scan_cnt #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .adv_i      (cnt_adv),
        .row_ofs_i  (row_ofs),
        .r_o        (r_cnt),
        .c_o        (c_cnt),
        .addr_o     (addr),
        .last_col_o (last_col),
        .last_row_o (last_row)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        row_ofs = 2'd0;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH0;
                    cnt_clr = 1'b1;
                end
            end
            FETCH0: state_d = FETCH1;
            FETCH1: begin
                row_ofs = 2'd1;
                d0_d    = mem_data_i;
                state_d = FETCH2;
            end
            FETCH2: begin
                row_ofs = 2'd2;
                d1_d    = mem_data_i;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (first_q) d2_d = mem_data_i;
                if (!hold_i) begin
                    cnt_adv = 1'b1;
                    state_d = (last_col && last_row) ? DONE : FETCH0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Row-2 data lands during the first ISSUE cycle; later ISSUE cycles use the captured copy.
        first_d = (state_q == FETCH2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        mem_rd_o     = (state_q == FETCH0) || (state_q == FETCH1) || (state_q == FETCH2);
        mem_addr_o   = mem_rd_o ? addr : '0;
        col_valid_o  = (state_q == ISSUE) && !hold_i;
        in_win       = (state_q == ISSUE) && (c_cnt >= CRD_W'(2));
        win_valid_o  = col_valid_o && in_win;
        win_x_o      = in_win ? 16'(c_cnt - CRD_W'(1)) : 16'd0;
        win_y_o      = in_win ? 16'(r_cnt + CRD_W'(1)) : 16'd0;
        busy_o       = (state_q != IDLE);
        frame_done_o = (state_q == DONE);
        col_d0_o     = d0_q;
        col_d1_o     = d1_q;
        col_d2_o     = first_q ? mem_data_i : d2_q;
    end

endmodule
